nanorv32_core: RTL and testbench

//  Multi-cycle, non-pipelined RV32I(+M) CPU core with a single shared valid/ready memory port.

---
 rtl/nanorv32_core_if.sv | 30 +++
 rtl/nanorv32_core.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_nanorv32_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_core_if.sv
// rtl/nanorv32_core_if.sv - shared instruction/data memory port of nanorv32_core
//
// Purpose: one valid/ready transfer channel used for both fetches and loads/stores.
// Signals:
//   mem_valid  request pending (master drives)
//   mem_instr  request is an instruction fetch (master drives)
//   mem_addr   word-aligned transfer address (master drives)
//   mem_wdata  lane-replicated store data (master drives)
//   mem_wstrb  byte write enables, 0 = read (master drives)
//   mem_ready  completion strobe (slave drives)
//   mem_rdata  read data, valid with mem_ready (slave drives)
interface nanorv32_core_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/nanorv32_core.sv
// rtl/nanorv32_core.sv - multi-cycle RV32I(+M) core on one shared memory port
//
// Purpose: non-pipelined FETCH -> EXEC -> (MEM | DIV) -> FETCH core; halts in TRAP on any fault.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous reset, active HIGH (1 = reset)
//   trap    sticky fault indicator
//   bus     nanorv32_core_if.master memory port (fetch and load/store)
module nanorv32_core #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0,
    parameter int          ENABLE_MUL     = 0,
    parameter int          ENABLE_DIV     = 0,
    parameter int          MACHINE_ISA    = 0,
    parameter int          COMPRESSED_ISA = 0,
    parameter int          ENABLE_TRACE   = 0
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            trap,
    nanorv32_core_if.master bus
);

    // Compatibility-only parameters: no hardware depends on them.
    if (COMPRESSED_ISA != 0 || ENABLE_TRACE != 0) begin : g_compat_params
    end

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_DIV, S_TRAP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] regs [0:31];
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic [1:0]  ld_off;

    logic [31:0] div_q, div_r, div_d;
    logic [5:0]  div_cnt;
    logic        div_neg_q, div_neg_r, div_is_rem;

    // Instruction fields
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1v, rs2v;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = insn[6:0];
    assign rd     = insn[11:7];
    assign f3     = insn[14:12];
    assign rs1    = insn[19:15];
    assign rs2    = insn[24:20];
    assign f7     = insn[31:25];
    assign rs1v   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};
    assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_u  = {insn[31:12], 12'd0};
    assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

    logic [31:0] jal_tgt, jalr_tgt, br_tgt, ea;
    assign jal_tgt  = pc + imm_j;
    assign jalr_tgt = (rs1v + imm_i) & ~32'd1;
    assign br_tgt   = pc + imm_b;
    assign ea       = rs1v + ((opcode == OP_STORE) ? imm_s : imm_i);

    // Zero/sign extension to 64 bits makes the low 64 product bits exact for every MULH flavour.
    logic        mul_a_sgn, mul_b_sgn;
    logic [63:0] mul_a, mul_b, mul_prod;
    logic [31:0] mul_res;
    assign mul_a_sgn = (f3 == 3'b001) || (f3 == 3'b010);
    assign mul_b_sgn = (f3 == 3'b001);
    assign mul_a     = {{32{mul_a_sgn & rs1v[31]}}, rs1v};
    assign mul_b     = {{32{mul_b_sgn & rs2v[31]}}, rs2v};
    assign mul_prod  = mul_a * mul_b;
    assign mul_res   = (f3 == 3'b000) ? mul_prod[31:0] : mul_prod[63:32];

    // Restoring divider step on magnitudes; signs are reapplied at the end.
    logic [32:0] div_shift, div_diff;
    logic [31:0] div_res;
    assign div_shift = {div_r, div_q[31]};
    assign div_diff  = div_shift - {1'b0, div_d};
    assign div_res   = div_is_rem ? (div_neg_r ? -div_r : div_r)
                                  : (div_neg_q ? -div_q : div_q);

    logic        div_signed, div_a_neg, div_b_neg;
    assign div_signed = ~f3[0];
    assign div_a_neg  = div_signed & rs1v[31];
    assign div_b_neg  = div_signed & rs2v[31];

    logic [31:0] ld_shift, load_val;
    assign ld_shift = bus.mem_rdata >> {ld_off, 3'b000};
    always_comb begin
        case (f3)
            3'b000:  load_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  load_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  load_val = {24'd0, ld_shift[7:0]};
            3'b101:  load_val = {16'd0, ld_shift[15:0]};
            default: load_val = ld_shift;
        endcase
    end

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op, input logic alt);
        case (op)
            3'b000:  alu = alt ? (a - b) : (a + b);
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  if (alt) alu = $signed(a) >>> b[4:0];
                     else     alu = a >> b[4:0];
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    // Decode / execute for the EXEC cycle
    logic        illegal, misalign, wb_en, is_mem, is_div, br_taken;
    logic [31:0] wb_val, next_pc, st_wdata;
    logic [3:0]  st_wstrb;

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        wb_en    = 1'b0;
        wb_val   = 32'd0;
        next_pc  = pc + 32'd4;
        is_mem   = 1'b0;
        is_div   = 1'b0;
        br_taken = 1'b0;
        st_wdata = rs2v;
        st_wstrb = 4'b0000;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OP_JAL: begin
                wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = jal_tgt;
                misalign = (jal_tgt[1:0] != 2'b00);
            end
            OP_JALR: begin
                illegal = (f3 != 3'b000);
                wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = jalr_tgt;
                misalign = (jalr_tgt[1:0] != 2'b00);
            end
            OP_BRANCH: begin
                case (f3)
                    3'b000:  br_taken = (rs1v == rs2v);
                    3'b001:  br_taken = (rs1v != rs2v);
                    3'b100:  br_taken = ($signed(rs1v) < $signed(rs2v));
                    3'b101:  br_taken = ($signed(rs1v) >= $signed(rs2v));
                    3'b110:  br_taken = (rs1v < rs2v);
                    3'b111:  br_taken = (rs1v >= rs2v);
                    default: illegal = 1'b1;
                endcase
                // Only a taken branch actually goes to its target.
                if (br_taken) begin
                    next_pc  = br_tgt;
                    misalign = (br_tgt[1:0] != 2'b00);
                end
            end
            OP_LOAD: begin
                is_mem = 1'b1;
                case (f3)
                    3'b000, 3'b100: ;
                    3'b001, 3'b101: misalign = ea[0];
                    3'b010:         misalign = (ea[1:0] != 2'b00);
                    default:        illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                is_mem = 1'b1;
                case (f3)
                    3'b000: begin st_wdata = {4{rs2v[7:0]}}; st_wstrb = 4'b0001 << ea[1:0]; end
                    3'b001: begin
                        st_wdata = {2{rs2v[15:0]}};
                        st_wstrb = ea[1] ? 4'b1100 : 4'b0011;
                        misalign = ea[0];
                    end
                    3'b010: begin st_wstrb = 4'b1111; misalign = (ea[1:0] != 2'b00); end
                    default: illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                wb_en  = 1'b1;
                wb_val = alu(rs1v, imm_i, f3, (f3 == 3'b101) && insn[30]);
                if (f3 == 3'b001) illegal = (f7 != 7'b0000000);
                if (f3 == 3'b101) illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OP_REG: begin
                if (f7 == 7'b0000001) begin
                    if (!f3[2]) begin
                        illegal = (ENABLE_MUL == 0);
                        wb_en   = 1'b1;
                        wb_val  = mul_res;
                    end else begin
                        illegal = (ENABLE_DIV == 0);
                        is_div  = 1'b1;
                    end
                end else if (f7 == 7'b0000000 ||
                             (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    wb_en  = 1'b1;
                    wb_val = alu(rs1v, rs2v, f3, insn[30]);
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_FENCE: illegal = (f3 != 3'b000) && (f3 != 3'b001);
            OP_SYSTEM: begin
                // Only CSRRS rd,<counter>,x0 is supported; everything else (ECALL/EBREAK too) faults.
                illegal = 1'b1;
                if (MACHINE_ISA != 0 && f3 == 3'b010 && rs1 == 5'd0) begin
                    case (insn[31:20])
                        12'hC00: begin illegal = 1'b0; wb_en = 1'b1; wb_val = cycle_cnt[31:0]; end
                        12'hC80: begin illegal = 1'b0; wb_en = 1'b1; wb_val = cycle_cnt[63:32]; end
                        12'hC02: begin illegal = 1'b0; wb_en = 1'b1; wb_val = instret_cnt[31:0]; end
                        12'hC82: begin illegal = 1'b0; wb_en = 1'b1; wb_val = instret_cnt[63:32]; end
                        default: ;
                    endcase
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    // Register file write port
    logic        rf_we;
    logic [31:0] rf_wdata;
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = wb_val;
        case (state)
            S_EXEC: rf_we = wb_en && !illegal && !misalign;
            S_MEM: begin
                rf_we    = bus.mem_valid && bus.mem_ready && (opcode == OP_LOAD);
                rf_wdata = load_val;
            end
            S_DIV: begin
                rf_we    = (div_cnt == 6'd0);
                rf_wdata = div_res;
            end
            default: ;
        endcase
        if (resetn || rd == 5'd0) rf_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rf_we) regs[rd] <= rf_wdata;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state         <= S_FETCH;
            pc            <= PROGADDR_RESET;
            insn          <= 32'd0;
            trap          <= 1'b0;
            bus.mem_valid <= 1'b0;
            bus.mem_instr <= 1'b0;
            bus.mem_addr  <= 32'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wstrb <= 4'd0;
            cycle_cnt     <= 64'd0;
            instret_cnt   <= 64'd0;
            ld_off        <= 2'd0;
            div_q         <= 32'd0;
            div_r         <= 32'd0;
            div_d         <= 32'd0;
            div_cnt       <= 6'd0;
            div_neg_q     <= 1'b0;
            div_neg_r     <= 1'b0;
            div_is_rem    <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            case (state)
                S_FETCH: begin
                    if (!bus.mem_valid) begin
                        bus.mem_valid <= 1'b1;
                        bus.mem_instr <= 1'b1;
                        bus.mem_addr  <= pc;
                        bus.mem_wstrb <= 4'd0;
                    end else if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_instr <= 1'b0;
                        insn          <= bus.mem_rdata;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (illegal || misalign) begin
                        trap  <= 1'b1;
                        state <= S_TRAP;
                    end else begin
                        pc <= next_pc;
                        if (is_mem) begin
                            bus.mem_valid <= 1'b1;
                            bus.mem_instr <= 1'b0;
                            bus.mem_addr  <= {ea[31:2], 2'b00};
                            bus.mem_wdata <= st_wdata;
                            bus.mem_wstrb <= st_wstrb;
                            ld_off        <= ea[1:0];
                            state         <= S_MEM;
                        end else if (is_div) begin
                            div_q      <= div_a_neg ? -rs1v : rs1v;
                            div_d      <= div_b_neg ? -rs2v : rs2v;
                            div_r      <= 32'd0;
                            div_cnt    <= 6'd32;
                            // Division by zero keeps the all-ones quotient unsigned.
                            div_neg_q  <= (div_a_neg ^ div_b_neg) && (rs2v != 32'd0);
                            div_neg_r  <= div_a_neg;
                            div_is_rem <= f3[1];
                            state      <= S_DIV;
                        end else begin
                            instret_cnt <= instret_cnt + 64'd1;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_wstrb <= 4'd0;
                        instret_cnt   <= instret_cnt + 64'd1;
                        state         <= S_FETCH;
                    end
                end
                S_DIV: begin
                    if (div_cnt != 6'd0) begin
                        div_r   <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                        div_q   <= {div_q[30:0], ~div_diff[32]};
                        div_cnt <= div_cnt - 6'd1;
                    end else begin
                        instret_cnt <= instret_cnt + 64'd1;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    bus.mem_valid <= 1'b0;
                    trap          <= 1'b1;
                    state         <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanorv32_core.sv
// tb/tb_nanorv32_core.sv - directed self-checking bench for nanorv32_core
module tb_nanorv32_core;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic trap;
    int   n_cmp = 0;
    int   n_fail = 0;

    nanorv32_core_if bus ();

    nanorv32_core #(
        .PROGADDR_RESET (32'h0),
        .ENABLE_MUL     (1),
        .ENABLE_DIV     (1),
        .MACHINE_ISA    (0),
        .COMPRESSED_ISA (0),
        .ENABLE_TRACE   (0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .trap   (trap),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [3:0]  wr_strb [$];
    logic [31:0] last_fetch = 32'hFFFF_FFFF;

    // Memory: ready one cycle after valid, driven away from the rising edge.
    initial begin : mem_model
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_valid && !bus.mem_ready) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[9:2]];
                if (bus.mem_instr) last_fetch = bus.mem_addr;
                if (bus.mem_wstrb != 4'd0) begin
                    wr_addr.push_back(bus.mem_addr);
                    wr_data.push_back(bus.mem_wdata);
                    wr_strb.push_back(bus.mem_wstrb);
                    if (bus.mem_addr[31:10] == 22'd0)
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;

    logic [31:0] exp_addr [0:13];
    logic [3:0]  exp_strb [0:13];
    logic [31:0] exp_data [0:13];

    initial begin : stimulus
        int cyc;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0]  = enc_i(12'h041, 0, 3'b000, 1, OPI);      // ADDI x1,x0,0x41
        mem[1]  = enc_u(20'h10000, 2);                    // LUI x2,0x10000
        mem[2]  = enc_s(12'h000, 1, 2, 3'b000);           // SB x1,0(x2)
        mem[3]  = enc_u(20'h20000, 3);                    // LUI x3,0x20000
        mem[4]  = enc_i(12'h0A5, 0, 3'b000, 4, OPI);      // ADDI x4,x0,0xA5
        mem[5]  = enc_s(12'h003, 4, 3, 3'b000);           // SB x4,3(x3)
        mem[6]  = enc_i(12'h201, 0, 3'b000, 6, LD);       // LB x6,0x201(x0)
        mem[7]  = enc_i(12'h203, 0, 3'b100, 7, LD);       // LBU x7,0x203(x0)
        mem[8]  = enc_i(12'h202, 0, 3'b001, 8, LD);       // LH x8,0x202(x0)
        mem[9]  = enc_s(12'h000, 6, 2, 3'b010);           // SW x6,0(x2)
        mem[10] = enc_s(12'h000, 7, 2, 3'b010);
        mem[11] = enc_s(12'h000, 8, 2, 3'b010);
        mem[12] = enc_i(12'h007, 0, 3'b000, 9, OPI);      // x9 = 7
        mem[13] = enc_i(12'hFFD, 0, 3'b000, 10, OPI);     // x10 = -3
        mem[14] = enc_r(7'h01, 10, 9, 3'b000, 11);        // MUL x11
        mem[15] = enc_s(12'h000, 11, 2, 3'b010);
        mem[16] = enc_i(12'h064, 0, 3'b000, 12, OPI);     // x12 = 100
        mem[17] = enc_r(7'h01, 0, 12, 3'b101, 13);        // DIVU x13,x12,x0
        mem[18] = enc_s(12'h000, 13, 2, 3'b010);
        mem[19] = enc_i(12'hFF9, 0, 3'b000, 14, OPI);     // x14 = -7
        mem[20] = enc_i(12'h002, 0, 3'b000, 15, OPI);     // x15 = 2
        mem[21] = enc_r(7'h01, 15, 14, 3'b110, 16);       // REM x16
        mem[22] = enc_s(12'h000, 16, 2, 3'b010);
        mem[23] = enc_i(12'hFFF, 0, 3'b000, 17, OPI);     // x17 = -1
        mem[24] = enc_r(7'h01, 17, 17, 3'b011, 18);       // MULHU x18
        mem[25] = enc_s(12'h000, 18, 2, 3'b010);
        mem[26] = enc_r(7'h20, 10, 9, 3'b000, 19);        // SUB x19
        mem[27] = enc_s(12'h000, 19, 2, 3'b010);
        mem[28] = enc_i(12'h401, 14, 3'b101, 20, OPI);    // SRAI x20,x14,1
        mem[29] = enc_s(12'h000, 20, 2, 3'b010);
        mem[30] = enc_r(7'h00, 9, 10, 3'b010, 21);        // SLT x21,x10,x9
        mem[31] = enc_s(12'h000, 21, 2, 3'b010);
        mem[32] = enc_i(12'h001, 0, 3'b000, 22, OPI);     // x22 = 1
        mem[33] = enc_b(13'd8, 10, 9, 3'b001);            // BNE x9,x10,+8
        mem[34] = enc_i(12'h055, 0, 3'b000, 22, OPI);     // skipped
        mem[35] = enc_s(12'h000, 22, 2, 3'b010);
        mem[36] = enc_u(20'h80000, 24);                   // x24 = 0x80000000
        mem[37] = enc_i(12'hFFF, 0, 3'b000, 25, OPI);     // x25 = -1
        mem[38] = enc_r(7'h01, 25, 24, 3'b100, 23);       // DIV x23
        mem[39] = enc_s(12'h000, 23, 2, 3'b010);
        mem[128] = 32'h80FF7F01;                          // load data at 0x200

        exp_addr[0] = 32'h10000000; exp_strb[0] = 4'b0001; exp_data[0] = 32'h41414141;
        exp_addr[1] = 32'h20000000; exp_strb[1] = 4'b1000; exp_data[1] = 32'hA5A5A5A5;
        for (int k = 2; k < 14; k++) begin exp_addr[k] = 32'h10000000; exp_strb[k] = 4'b1111; end
        exp_data[2]  = 32'h0000007F;
        exp_data[3]  = 32'h00000080;
        exp_data[4]  = 32'hFFFF80FF;
        exp_data[5]  = 32'hFFFFFFEB;
        exp_data[6]  = 32'hFFFFFFFF;
        exp_data[7]  = 32'hFFFFFFFF;
        exp_data[8]  = 32'hFFFFFFFE;
        exp_data[9]  = 32'h0000000A;
        exp_data[10] = 32'hFFFFFFFC;
        exp_data[11] = 32'h00000001;
        exp_data[12] = 32'h00000001;
        exp_data[13] = 32'h80000000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_instr", 32'(bus.mem_instr), 32'd0);
        check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_trap", 32'(trap), 32'd0);

        resetn = 1'b0;
        @(posedge clk); #1;
        check("fetch0_valid", 32'(bus.mem_valid), 32'd1);
        check("fetch0_addr", bus.mem_addr, 32'd0);
        check("fetch0_instr", 32'(bus.mem_instr), 32'd1);
        check("fetch0_wstrb", 32'(bus.mem_wstrb), 32'd0);
        @(posedge clk); #1;
        check("fetch0_drop", 32'(bus.mem_valid), 32'd0);

        cyc = 0;
        while (!trap && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("trap_raised", 32'(trap), 32'd1);
        check("last_fetch", last_fetch, 32'h000000A0);
        check("n_writes", 32'(wr_addr.size()), 32'd14);
        for (int k = 0; k < 14; k++) begin
            if (k < wr_addr.size()) begin
                check($sformatf("wr%0d_addr", k), wr_addr[k], exp_addr[k]);
                check($sformatf("wr%0d_strb", k), 32'(wr_strb[k]), 32'(exp_strb[k]));
                check($sformatf("wr%0d_data", k), wr_data[k], exp_data[k]);
            end
        end

        repeat (4) begin
            @(posedge clk); #1;
            check("trap_valid_low", 32'(bus.mem_valid), 32'd0);
            check("trap_sticky", 32'(trap), 32'd1);
        end

        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst2_trap", 32'(trap), 32'd0);
        check("rst2_valid", 32'(bus.mem_valid), 32'd0);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("refetch_valid", 32'(bus.mem_valid), 32'd1);
        check("refetch_addr", bus.mem_addr, 32'd0);
        check("refetch_instr", 32'(bus.mem_instr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
